// File: rtl/apu_frame_sequencer_if.sv
// apu_frame_sequencer_if
// Bundles the CPU-side control inputs and the strobe/interrupt outputs of the
// APU frame sequencer.
//   master : register/bus side (drives cpu_clk_en, load, mode,
//            inhibit_interrupt, irq_ack; observes the strobes, interrupt, step)
//   slave  : the frame sequencer itself
interface apu_frame_sequencer_if;
    logic       cpu_clk_en;
    logic       load;
    logic       mode;
    logic       inhibit_interrupt;
    logic       irq_ack;
    logic       quarter_clk_en;
    logic       half_clk_en;
    logic       interrupt;
    logic [2:0] step;

    modport master (
        output cpu_clk_en, load, mode, inhibit_interrupt, irq_ack,
        input  quarter_clk_en, half_clk_en, interrupt, step
    );

    modport slave (
        input  cpu_clk_en, load, mode, inhibit_interrupt, irq_ack,
        output quarter_clk_en, half_clk_en, interrupt, step
    );
endinterface

// File: rtl/apu_frame_sequencer.sv
// apu_frame_sequencer
// Divides the CPU clock-enable stream into quarter-frame and half-frame strobes
// and raises the frame interrupt. Step positions, counter width and the
// parity-dependent write-to-reset delay are parameters.
// Ports:
//   clk   : system clock
//   rst_l : synchronous active-low reset
//   bus   : apu_frame_sequencer_if.slave
//           in : cpu_clk_en, load, mode, inhibit_interrupt, irq_ack
//           out: quarter_clk_en, half_clk_en (combinational, gated by
//                cpu_clk_en), interrupt (level), step (last fired step, 0-5)
// Build option:
//   APU_FS_IRQ_EN : when defined, the frame interrupt flag and its
//                   irq_ack / inhibit handling are built; otherwise interrupt
//                   is tied low and irq_ack / inhibit_interrupt are ignored.
module apu_frame_sequencer #(
    parameter int unsigned CNT_W    = 16,
    parameter int unsigned STEP1    = 7457,
    parameter int unsigned STEP2    = 14913,
    parameter int unsigned STEP3    = 22371,
    parameter int unsigned STEP4    = 29829,
    parameter int unsigned STEP5    = 37281,
    parameter int unsigned DLY_EVEN = 3,
    parameter int unsigned DLY_ODD  = 4
) (
    input logic                  clk,
    input logic                  rst_l,
    apu_frame_sequencer_if.slave bus
);

    localparam logic [CNT_W-1:0] S1 = CNT_W'(STEP1);
    localparam logic [CNT_W-1:0] S2 = CNT_W'(STEP2);
    localparam logic [CNT_W-1:0] S3 = CNT_W'(STEP3);
    localparam logic [CNT_W-1:0] S4 = CNT_W'(STEP4);
    localparam logic [CNT_W-1:0] S5 = CNT_W'(STEP5);
    localparam logic [2:0]       D_EVEN = 3'(DLY_EVEN);
    localparam logic [2:0]       D_ODD  = 3'(DLY_ODD);

    generate
        if (!(STEP1 < STEP2 && STEP2 < STEP3 && STEP3 < STEP4 && STEP4 < STEP5 &&
              64'(STEP5) < (64'd1 << CNT_W))) begin : g_param_check
            $error("apu_frame_sequencer: STEP1..STEP5 must be strictly increasing and fit in CNT_W bits");
        end
    endgenerate

    logic [CNT_W-1:0] cnt_r;
    logic             mode_r;
    logic             parity_r;
    logic [2:0]       dly_r;
    logic [2:0]       step_r;

    logic [CNT_W-1:0] last_s;
    logic             expire_s;
    logic             quarter_s;
    logic             half_s;
    logic [2:0]       fire_idx_s;

    assign last_s = mode_r ? S5 : S4;
    // A load landing on the expiry cycle restarts the delay instead of expiring.
    assign expire_s = bus.cpu_clk_en & (dly_r == 3'd1) & ~bus.load;

    // Strobe decode: delay expiry replaces any normal step strobe.
    always_comb begin
        quarter_s  = 1'b0;
        half_s     = 1'b0;
        fire_idx_s = 3'd0;
        if (!rst_l || !bus.cpu_clk_en) begin
            quarter_s = 1'b0;
        end else if (expire_s) begin
            quarter_s = mode_r;
            half_s    = mode_r;
        end else if (cnt_r == S1) begin
            quarter_s  = 1'b1;
            fire_idx_s = 3'd1;
        end else if (cnt_r == S2) begin
            quarter_s  = 1'b1;
            half_s     = 1'b1;
            fire_idx_s = 3'd2;
        end else if (cnt_r == S3) begin
            quarter_s  = 1'b1;
            fire_idx_s = 3'd3;
        end else if (cnt_r == S4 && !mode_r) begin
            quarter_s  = 1'b1;
            half_s     = 1'b1;
            fire_idx_s = 3'd4;
        end else if (cnt_r == S5 && mode_r) begin
            quarter_s  = 1'b1;
            half_s     = 1'b1;
            fire_idx_s = 3'd5;
        end else begin
            fire_idx_s = 3'd0;
        end
    end

    assign bus.quarter_clk_en = quarter_s;
    assign bus.half_clk_en    = half_s;
    assign bus.step           = step_r;

    // Step counter, cycle parity, pending-reset countdown, mode and step index.
    always_ff @(posedge clk) begin
        if (!rst_l) begin
            cnt_r    <= '0;
            mode_r   <= 1'b0;
            parity_r <= 1'b0;
            dly_r    <= 3'd0;
            step_r   <= 3'd0;
        end else begin
            if (bus.cpu_clk_en) begin
                parity_r <= ~parity_r;
                if (expire_s || cnt_r == last_s) begin
                    cnt_r <= '0;
                end else begin
                    cnt_r <= cnt_r + CNT_W'(1);
                end
            end else begin
                cnt_r <= cnt_r;
            end

            if (bus.load) begin
                mode_r <= bus.mode;
                dly_r  <= parity_r ? D_ODD : D_EVEN;
            end else if (bus.cpu_clk_en && dly_r != 3'd0) begin
                dly_r  <= dly_r - 3'd1;
            end else begin
                dly_r  <= dly_r;
            end

            // The index returns to 0 on the count following a wrap to 0.
            if (expire_s) begin
                step_r <= 3'd0;
            end else if (fire_idx_s != 3'd0) begin
                step_r <= fire_idx_s;
            end else if (bus.cpu_clk_en && cnt_r == '0) begin
                step_r <= 3'd0;
            end else begin
                step_r <= step_r;
            end
        end
    end

`ifdef APU_FS_IRQ_EN
    logic inh_r;
    logic irq_r;
    logic irq_set_s;
    logic irq_clr_s;

    assign irq_set_s = bus.cpu_clk_en & (cnt_r == S4) & ~mode_r & ~inh_r;
    assign irq_clr_s = bus.irq_ack | (bus.load & bus.inhibit_interrupt);

    // Frame interrupt flag; a set in the same clock as a clear wins.
    always_ff @(posedge clk) begin
        if (!rst_l) begin
            inh_r <= 1'b0;
            irq_r <= 1'b0;
        end else begin
            if (bus.load) begin
                inh_r <= bus.inhibit_interrupt;
            end else begin
                inh_r <= inh_r;
            end
            if (irq_set_s) begin
                irq_r <= 1'b1;
            end else if (irq_clr_s) begin
                irq_r <= 1'b0;
            end else begin
                irq_r <= irq_r;
            end
        end
    end

    assign bus.interrupt = irq_r;
`else
    logic unused_irq_s;
    assign unused_irq_s  = &{1'b0, bus.irq_ack, bus.inhibit_interrupt};
    assign bus.interrupt = 1'b0;
`endif

endmodule
